// File: rtl/owt_mcst_rx_ctrl.sv
// Manchester one-wire frame receiver control.
// Decodes qualified half-bit symbols into a frame: sync head of Manchester 0s, raw sync tail,
// command, normal or long data, CRC and raw end tail. It reports each terminated frame with
// an error code and keeps a saturating error count.
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_sym_vld, i_sym_data      one-cycle symbol strobe and its level
//   i_exp_cmd, i_exp_cmd_en    expected command echo and its check enable
//   i_cnt_clr                  synchronous clear of the error counter
//   o_busy                     receiver not idle
//   o_frm_done/o_frm_err       frame termination pulse and error flag
//   o_err_code                 termination code (0 ok, 1 bad pair, 2 sync tail, 3 CRC,
//                              4 end tail, 5 timeout, 6 command echo)
//   o_cmd, o_data, o_long      last good frame contents
//   o_err_cnt                  saturating count of errored frames
module owt_mcst_rx_ctrl #(
    parameter int unsigned       SYNC_N    = 12,
    parameter int unsigned       TAIL_N    = 4,
    parameter logic [TAIL_N-1:0] TAIL_PAT  = 4'b1100,
    parameter int unsigned       CMD_W     = 8,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       LONG_W    = 10,
    parameter logic [CMD_W-2:0]  LONG_CODE = 7'h1f,
    parameter int unsigned       CRC_W     = 8,
    parameter logic [CRC_W-1:0]  CRC_POLY  = 8'h07,
    parameter logic [CRC_W-1:0]  CRC_INIT  = 8'h00,
    parameter int unsigned       TO_CYC    = 255,
    parameter int unsigned       ECNT_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sym_vld,
    input  logic              i_sym_data,
    input  logic [CMD_W-1:0]  i_exp_cmd,
    input  logic              i_exp_cmd_en,
    input  logic              i_cnt_clr,
    output logic              o_busy,
    output logic              o_frm_done,
    output logic              o_frm_err,
    output logic [2:0]        o_err_code,
    output logic [CMD_W-1:0]  o_cmd,
    output logic [LONG_W-1:0] o_data,
    output logic              o_long,
    output logic [ECNT_W-1:0] o_err_cnt
);

    localparam int unsigned MAX_A = (SYNC_N > CMD_W) ? SYNC_N : CMD_W;
    localparam int unsigned MAX_B = (LONG_W > CRC_W) ? LONG_W : CRC_W;
    localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_N = (MAX_C > TAIL_N) ? MAX_C : TAIL_N;
    localparam int unsigned CNT_W = $clog2(MAX_N + 1);
    localparam int unsigned TO_W  = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {
        StIdle, StSync, StStail, StCmd, StData, StLdata, StCrc, StEtail
    } state_e;

    state_e            state_q, state_d;
    logic              half_q, half_d;
    logic              half_vld_q, half_vld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [TAIL_N-1:0] tail_q, tail_d, tail_next;
    logic [CMD_W-1:0]  cmd_q, cmd_d, cmd_next;
    logic [LONG_W-1:0] data_q, data_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic [CRC_W-1:0]  crc_rx_q, crc_rx_d;
    logic              long_q, long_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              term;
    logic [2:0]        code;
    logic              pair_ok, dbit;

    logic              busy_q, done_q, frm_err_q, out_long_q;
    logic [2:0]        code_q;
    logic [CMD_W-1:0]  out_cmd_q;
    logic [LONG_W-1:0] out_data_q;
    logic [ECNT_W-1:0] err_cnt_q;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
        logic fb;
        fb = c[CRC_W-1] ^ b;
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        half_vld_d = half_vld_q;
        cnt_d      = cnt_q;
        tail_d     = tail_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        crc_d      = crc_q;
        crc_rx_d   = crc_rx_q;
        long_d     = long_q;
        to_d       = to_q;
        term       = 1'b0;
        code       = 3'd0;
        pair_ok    = half_q ^ i_sym_data;
        dbit       = half_q;
        cnt_inc    = cnt_q + CNT_W'(1);
        tail_next  = {tail_q[TAIL_N-2:0], i_sym_data};
        cmd_next   = {cmd_q[CMD_W-2:0], dbit};

        // to_q counts idle clocks since the last symbol; terminate on the TO_CYC-th one.
        if (state_q != StIdle) begin
            if (i_sym_vld) begin
                to_d = '0;
            end else if (to_q == TO_W'(TO_CYC - 1)) begin
                term = 1'b1;
                code = 3'd5;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                // The starting 0 is the first half of sync bit 0.
                if (i_sym_vld && !i_sym_data) begin
                    state_d = StSync;
                    half_d  = 1'b0;
                end
            end
            StSync: begin
                if (i_sym_vld) begin
                    if (!half_vld_q) begin
                        half_d     = i_sym_data;
                        half_vld_d = 1'b1;
                    end else begin
                        half_vld_d = 1'b0;
                        if (!pair_ok || dbit) begin
                            state_d = StIdle;
                        end else if (cnt_q == CNT_W'(SYNC_N - 1)) begin
                            state_d = StStail;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
            end
            StCmd, StData, StLdata, StCrc: begin
                if (i_sym_vld) begin
                    if (!half_vld_q) begin
                        half_d     = i_sym_data;
                        half_vld_d = 1'b1;
                    end else begin
                        half_vld_d = 1'b0;
                        cnt_d      = cnt_inc;
                        if (!pair_ok) begin
                            term = 1'b1;
                            code = 3'd1;
                        end else begin
                            case (state_q)
                                StCmd: begin
                                    cmd_d = cmd_next;
                                    crc_d = crc_step(crc_q, dbit);
                                    if (cnt_q == CNT_W'(CMD_W - 1)) begin
                                        data_d = '0;
                                        if (!cmd_next[CMD_W-1] &&
                                            cmd_next[CMD_W-2:0] == LONG_CODE) begin
                                            state_d = StLdata;
                                            long_d  = 1'b1;
                                        end else begin
                                            state_d = StData;
                                            long_d  = 1'b0;
                                        end
                                    end
                                end
                                StData, StLdata: begin
                                    data_d = {data_q[LONG_W-2:0], dbit};
                                    crc_d  = crc_step(crc_q, dbit);
                                    if ((state_q == StData  && cnt_q == CNT_W'(DATA_W - 1)) ||
                                        (state_q == StLdata && cnt_q == CNT_W'(LONG_W - 1))) begin
                                        state_d = StCrc;
                                    end
                                end
                                default: begin
                                    crc_rx_d = {crc_rx_q[CRC_W-2:0], dbit};
                                    if (cnt_q == CNT_W'(CRC_W - 1)) begin
                                        state_d = StEtail;
                                    end
                                end
                            endcase
                        end
                    end
                end
            end
            StStail, StEtail: begin
                if (i_sym_vld) begin
                    tail_d = tail_next;
                    cnt_d  = cnt_inc;
                    if (cnt_q == CNT_W'(TAIL_N - 1)) begin
                        if (state_q == StStail) begin
                            if (tail_next == TAIL_PAT) begin
                                state_d = StCmd;
                                crc_d   = CRC_INIT;
                            end else begin
                                term = 1'b1;
                                code = 3'd2;
                            end
                        end else begin
                            term = 1'b1;
                            if (tail_next != TAIL_PAT) begin
                                code = 3'd4;
                            end else if (crc_rx_q != crc_q) begin
                                code = 3'd3;
                            end else if (i_exp_cmd_en && cmd_q != i_exp_cmd) begin
                                code = 3'd6;
                            end else begin
                                code = 3'd0;
                            end
                        end
                    end
                end
            end
        endcase

        if (term) begin
            state_d = StIdle;
        end
        // Every state entry restarts the bit count and pair phase, except IDLE->SYNC
        // where the entering symbol is already the first half.
        if (state_d != state_q) begin
            cnt_d      = '0;
            half_vld_d = (state_q == StIdle);
        end
        if (state_d == StIdle) begin
            to_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            half_q     <= 1'b0;
            half_vld_q <= 1'b0;
            cnt_q      <= '0;
            tail_q     <= '0;
            cmd_q      <= '0;
            data_q     <= '0;
            crc_q      <= CRC_INIT;
            crc_rx_q   <= '0;
            long_q     <= 1'b0;
            to_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            frm_err_q  <= 1'b0;
            code_q     <= 3'd0;
            out_cmd_q  <= '0;
            out_data_q <= '0;
            out_long_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            half_vld_q <= half_vld_d;
            cnt_q      <= cnt_d;
            tail_q     <= tail_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            crc_q      <= crc_d;
            crc_rx_q   <= crc_rx_d;
            long_q     <= long_d;
            to_q       <= to_d;
            busy_q     <= (state_d != StIdle);
            done_q     <= term;
            if (term) begin
                code_q    <= code;
                frm_err_q <= (code != 3'd0);
                if (code == 3'd0) begin
                    out_cmd_q  <= cmd_q;
                    out_data_q <= data_q;
                    out_long_q <= long_q;
                end
            end
            if (i_cnt_clr) begin
                err_cnt_q <= '0;
            end else if (done_q && frm_err_q && err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + ECNT_W'(1);
            end
        end
    end

    assign o_busy     = busy_q;
    assign o_frm_done = done_q;
    assign o_frm_err  = frm_err_q;
    assign o_err_code = code_q;
    assign o_cmd      = out_cmd_q;
    assign o_data     = out_data_q;
    assign o_long     = out_long_q;
    assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_owt_mcst_rx_ctrl.sv
// Scoreboard bench for owt_mcst_rx_ctrl with default parameters.
module tb_owt_mcst_rx_ctrl;

    localparam int TO_CYC = 255;
    localparam logic [3:0] GOOD_TAIL = 4'b1100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sym_vld = 1'b0;
    logic       sym_data = 1'b0;
    logic [7:0] exp_cmd = 8'h00;
    logic       exp_cmd_en = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       busy, frm_done, frm_err, lng;
    logic [2:0] err_code;
    logic [7:0] cmd;
    logic [9:0] data;
    logic [7:0] err_cnt;

    owt_mcst_rx_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sym_vld    (sym_vld),
        .i_sym_data   (sym_data),
        .i_exp_cmd    (exp_cmd),
        .i_exp_cmd_en (exp_cmd_en),
        .i_cnt_clr    (cnt_clr),
        .o_busy       (busy),
        .o_frm_done   (frm_done),
        .o_frm_err    (frm_err),
        .o_err_code   (err_code),
        .o_cmd        (cmd),
        .o_data       (data),
        .o_long       (lng),
        .o_err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] code;
        logic [7:0] cmd;
        logic [9:0] data;
        logic       lng;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    bit         syms[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         last_idx = 0;
    logic [7:0] m_cmd = 8'h00;
    logic [9:0] m_data = 10'h000;
    logic       m_long = 1'b0;
    int         m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_long(input logic [7:0] c);
        return !c[7] && (c[6:0] == 7'h1f);
    endfunction

    function automatic logic [7:0] crc_of(input logic [7:0] c, input logic [9:0] d, input bit l);
        logic [7:0] r;
        logic       fb;
        int         nd;
        r  = 8'h00;
        nd = l ? 10 : 8;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ c[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        for (int i = nd - 1; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    task automatic push_bit(input bit b);
        syms.push_back(b);
        syms.push_back(!b);
    endtask

    task automatic push_raw(input logic [3:0] p);
        for (int i = 3; i >= 0; i--) syms.push_back(p[i]);
    endtask

    task automatic build(input logic [7:0] c, input logic [9:0] d, input logic [7:0] crc_x,
                         input logic [3:0] st, input logic [3:0] et);
        bit         l;
        logic [7:0] crc;
        l   = is_long(c);
        crc = crc_of(c, d, l) ^ crc_x;
        syms.delete();
        repeat (12) push_bit(1'b0);
        push_raw(st);
        for (int i = 7; i >= 0; i--) push_bit(c[i]);
        for (int i = (l ? 9 : 7); i >= 0; i--) push_bit(d[i]);
        for (int i = 7; i >= 0; i--) push_bit(crc[i]);
        push_raw(et);
    endtask

    task automatic truncate(input int n);
        while (syms.size() > n) void'(syms.pop_back());
    endtask

    // Expected termination; lat is clocks from the last symbol cycle to the done pulse.
    task automatic expect_frm(input logic [2:0] code, input logic [7:0] c, input logic [9:0] d,
                              input int lat);
        exp_t e;
        if (code == 3'd0) begin
            m_cmd  = c;
            m_data = d;
            m_long = is_long(c);
        end else if (m_cnt < 255) begin
            m_cnt++;
        end
        e.code = code;
        e.cmd  = m_cmd;
        e.data = m_data;
        e.lng  = m_long;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic play();
        foreach (syms[i]) begin
            @(negedge clk);
            sym_vld  = 1'b1;
            sym_data = syms[i];
            last_idx = cyc;
        end
        @(negedge clk);
        sym_vld = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && frm_done) begin
            check("done_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("err_code", err_code, e.code);
                check("frm_err", frm_err, e.code != 3'd0);
                check("cmd", cmd, e.cmd);
                check("data", data, e.data);
                check("long", lng, e.lng);
                check("latency", cyc - last_idx, e.lat);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, frm_done, 0);
        check({tag, "_err"}, frm_err, 0);
        check({tag, "_code"}, err_code, 0);
        check({tag, "_cmd"}, cmd, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_long"}, lng, 0);
        check({tag, "_cnt"}, err_cnt, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good short frame, all zero.
        build(8'h00, 10'h000, 8'h00, GOOD_TAIL, GOOD_TAIL);
        expect_frm(3'd0, 8'h00, 10'h000, 1);
        play();
        drain();

        // Long read, then the same with one CRC bit flipped.
        build(8'h1f, 10'h3a5, 8'h00, GOOD_TAIL, GOOD_TAIL);
        expect_frm(3'd0, 8'h1f, 10'h3a5, 1);
        play();
        drain();
        build(8'h1f, 10'h3a5, 8'h10, GOOD_TAIL, GOOD_TAIL);
        expect_frm(3'd3, 8'h1f, 10'h3a5, 1);
        play();
        drain();
        check("err_cnt_after_crc", err_cnt, 1);

        // Equal pair (1,1) at cmd bit 3, then a good frame.
        build(8'h5a, 10'h033, 8'h00, GOOD_TAIL, GOOD_TAIL);
        syms[34] = 1'b1;
        syms[35] = 1'b1;
        truncate(36);
        expect_frm(3'd1, 8'h5a, 10'h033, 1);
        play();
        drain();
        build(8'h5a, 10'h0c3, 8'h00, GOOD_TAIL, GOOD_TAIL);
        expect_frm(3'd0, 8'h5a, 10'h0c3, 1);
        play();
        drain();

        // Symbols stop after data bit 2.
        build(8'h22, 10'h081, 8'h00, GOOD_TAIL, GOOD_TAIL);
        truncate(50);
        expect_frm(3'd5, 8'h22, 10'h081, TO_CYC + 1);
        play();
        drain();

        // Bad sync tail, bad end tail, command echo mismatch.
        build(8'h00, 10'h000, 8'h00, 4'b1010, GOOD_TAIL);
        truncate(28);
        expect_frm(3'd2, 8'h00, 10'h000, 1);
        play();
        drain();
        build(8'h81, 10'h0f0, 8'h00, GOOD_TAIL, 4'b1101);
        expect_frm(3'd4, 8'h81, 10'h0f0, 1);
        play();
        drain();
        exp_cmd    = 8'h01;
        exp_cmd_en = 1'b1;
        build(8'h00, 10'h000, 8'h00, GOOD_TAIL, GOOD_TAIL);
        expect_frm(3'd6, 8'h00, 10'h000, 1);
        play();
        drain();
        exp_cmd_en = 1'b0;
        check("err_cnt_mid", err_cnt, 32'(m_cnt));

        // Saturation of the error counter, then clear.
        for (int k = 0; k < 256; k++) begin
            build(8'h00, 10'h000, 8'h00, 4'b1010, GOOD_TAIL);
            truncate(28);
            expect_frm(3'd2, 8'h00, 10'h000, 1);
            play();
            drain();
        end
        check("err_cnt_sat", err_cnt, 8'hff);
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        m_cnt   = 0;
        check("err_cnt_clr", err_cnt, 0);

        // Reset during DATA aborts silently.
        build(8'h12, 10'h034, 8'h00, GOOD_TAIL, GOOD_TAIL);
        truncate(48);
        play();
        check("busy_mid_frame", busy, 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("mid_rst");
        m_cmd  = 8'h00;
        m_data = 10'h000;
        m_long = 1'b0;
        rst_n  = 1'b1;
        repeat (2) @(negedge clk);
        build(8'h81, 10'h07e, 8'h00, GOOD_TAIL, GOOD_TAIL);
        expect_frm(3'd0, 8'h81, 10'h07e, 1);
        play();
        drain();
        check("busy_end", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/owt_mcst_rx_ctrl.md
OWT_MCST_RX_CTRL -- requirements
Module: owt_mcst_rx_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- SYNC_N, 12: Manchester-0 bits in the sync head.
- TAIL_N, 4: raw half-bit symbols in each tail.
- TAIL_PAT, 4'b1100: required value of each tail, first symbol in MSB.
- CMD_W, 8: command bits; the MSB is R/W (1 = write).
- DATA_W, 8: data bits in a normal frame.
- LONG_W, 10: data bits in a long frame; LONG_W >= DATA_W.
- LONG_CODE, 7'h1f: value of cmd[CMD_W-2:0] that, on a read, selects a long frame.
- CRC_W, 8: CRC width.
- CRC_POLY, 8'h07: CRC polynomial.
- CRC_INIT, 8'h00: CRC seed.
- TO_CYC, 255: inter-symbol timeout in clocks.
- ECNT_W, 8: error counter width.

REQ-002 Ports, one per line: name, direction, width, meaning.
- i_clk, in, 1: clock.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_sym_vld, in, 1: one-cycle strobe marking one qualified half-bit symbol.
- i_sym_data, in, 1: symbol level.
- i_exp_cmd, in, CMD_W: command expected back.
- i_exp_cmd_en, in, 1: enables the command-echo check.
- i_cnt_clr, in, 1: synchronous clear of the error counter.
- o_busy, out, 1: high when the FSM is not in IDLE.
- o_frm_done, out, 1: one-cycle pulse when a frame terminates.
- o_frm_err, out, 1: valid with o_frm_done.
- o_err_code, out, 3: valid with o_frm_done.
- o_cmd, out, CMD_W: last received command.
- o_data, out, LONG_W: last received data, zero-extended.
- o_long, out, 1: last frame was long.
- o_err_cnt, out, ECNT_W: saturating error count.

Function
REQ-003 Manchester decoding works on symbol pairs (first half, second half): 1,0 decodes as bit 1; 0,1 decodes as bit 0; equal halves are invalid (MINV).
REQ-004 The pair phase resets to "first half" on every state entry, except where REQ-005 states otherwise.
REQ-005 IDLE: a symbol of 0 moves the FSM to SYNC, and that symbol counts as the first half of sync bit 0. A symbol of 1 is ignored.
REQ-006 SYNC: each decoded 0 increments the bit counter.
- A decoded 1 or an invalid pair returns the FSM to IDLE silently: no o_frm_done, no counter change.
- After SYNC_N zero bits the FSM moves to STAIL.
REQ-007 STAIL: TAIL_N raw symbols are shifted in.
- If they equal TAIL_PAT, the FSM moves to CMD.
- Otherwise the frame terminates with code 2.
REQ-008 CMD: CMD_W bits are shifted in MSB first.
- Go to LDATA if cmd MSB = 0 and cmd[CMD_W-2:0] = LONG_CODE.
- Otherwise go to DATA.
REQ-009 DATA and LDATA receive DATA_W and LONG_W bits respectively, MSB first; then the FSM moves to CRC.
REQ-010 CRC: CRC_W bits are received, then the FSM moves to ETAIL.
REQ-011 ETAIL: TAIL_N raw symbols are received, then the frame terminates.
REQ-012 Any invalid pair in the CMD, DATA, LDATA or CRC states terminates the frame immediately with code 1.
REQ-013 CRC calculation:
- Serial, MSB first, over the cmd bits followed by the data bits.
- Seeded with CRC_INIT on the first cmd bit.
- Update rule: fb = crc[CRC_W-1] ^ bit; crc = {crc[CRC_W-2:0],1'b0} ^ (fb ? CRC_POLY : 0).
REQ-014 Checks at normal termination (end of ETAIL), in priority order:
- ETAIL symbols != TAIL_PAT: code 4.
- Received CRC != computed CRC: code 3.
- i_exp_cmd_en = 1 and cmd != i_exp_cmd: code 6.
- Otherwise: code 0.
REQ-015 Timeout: in any non-IDLE state, TO_CYC consecutive clocks without i_sym_vld terminate the frame with code 5. The timeout counter reloads on every i_sym_vld.
REQ-016 Termination behaviour:
- The FSM returns to IDLE.
- o_frm_done pulses one cycle after the terminating symbol or timeout clock.
- o_frm_err = (code != 0).
- o_cmd, o_data and o_long update only on code 0; they hold their values on error.
REQ-017 Error counter:
- o_err_cnt increments on each o_frm_done with o_frm_err, saturating at all-ones.
- i_cnt_clr has priority; a clear coinciding with an error pulse yields 0.
REQ-018 A symbol arriving on the same cycle as the termination is discarded. Reception restarts only from IDLE.
REQ-019 o_busy = (state != IDLE), driven from a register.

Reset
REQ-020 While i_rst_n = 0, the following hold:
- FSM in IDLE.
- All counters at 0, CRC at CRC_INIT.
- o_busy, o_frm_done, o_frm_err, o_long = 0.
- o_err_code = 0, o_cmd = 0, o_data = 0, o_err_cnt = 0.
REQ-021 Reset asserted mid-frame aborts the frame without an o_frm_done pulse.

Verification
REQ-022 Good short frame: default parameters, 12 sync 0s, tail 1100, cmd 0x00, data 0x00, crc 0x00, tail 1100 -> one o_frm_done, o_frm_err = 0, o_cmd = 0x00, o_data = 0x000, o_long = 0.
REQ-023 Long read: cmd 0x1F, 10-bit data 0x3A5 with its correct CRC -> o_long = 1, o_data = 0x3A5, code 0; the same frame with one CRC bit flipped -> code 3, o_cmd and o_data unchanged, o_err_cnt = 1.
REQ-024 Equal pair (1,1) injected at cmd bit 3 -> o_frm_done with code 1 on the cycle after that symbol; the following good frame decodes correctly.
REQ-025 Symbols stop after data bit 2 -> o_frm_done with code 5 exactly TO_CYC+1 clocks after the last symbol.
REQ-026 Sync tail 1010 -> code 2; good frame with i_exp_cmd_en = 1 and i_exp_cmd = 0x01 -> code 6; 256 error frames -> o_err_cnt holds at 0xFF; i_cnt_clr -> 0.
REQ-027 i_rst_n pulsed low during DATA -> no o_frm_done, all outputs at reset values, next good frame accepted.
